// File: rtl/omp_pkg.sv
// Shared definitions for the MGS/OMP datapath.
// Q10.13 lane format, 4-lane word packing, saturation limits, the FSM
// state type of the projection engine, and lane pack/unpack helpers.
package omp_pkg;

  localparam int DATA_W = 24;
  localparam int FRAC_W = 13;
  localparam int LANES  = 4;
  localparam int WORD_W = DATA_W * LANES;
  localparam int PROD_W = 2 * DATA_W;   // Q20.26 lane product
  localparam int SUM_W  = PROD_W + 2;   // sum of four products, no overflow

  localparam logic signed [DATA_W-1:0] SAT_POS = 24'sh7FFFFF;
  localparam logic signed [DATA_W-1:0] SAT_NEG = 24'sh800000;

  typedef logic signed [DATA_W-1:0] lane_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_OUT
  } dp_state_t;

  function automatic lane_t get_lane(input logic [WORD_W-1:0] word, input int idx);
    return lane_t'(word[idx*DATA_W +: DATA_W]);
  endfunction

  function automatic logic [WORD_W-1:0] pack_lanes(input lane_t l3, input lane_t l2,
                                                   input lane_t l1, input lane_t l0);
    return {l3, l2, l1, l0};
  endfunction

endpackage

// File: rtl/dot4_lane.sv
// Combinational 4-lane signed dot product.
// Ports:
//   vec_a, vec_b : packed words {x3,x2,x1,x0}, 24-bit signed Q10.13 lanes
//   sum          : 50-bit signed Q22.26 sum of the four lane products
// The caller is expected to register sum.
module dot4_lane
  import omp_pkg::*;
(
  input  logic [WORD_W-1:0]       vec_a,
  input  logic [WORD_W-1:0]       vec_b,
  output logic signed [SUM_W-1:0] sum
);

  logic signed [PROD_W-1:0] prod [LANES];

  always_comb begin
    sum = '0;
    for (int i = 0; i < LANES; i++) begin
      prod[i] = PROD_W'(get_lane(vec_a, i)) * PROD_W'(get_lane(vec_b, i));
      sum     = sum + SUM_W'(prod[i]);
    end
  end

endmodule

// File: rtl/vec_dot_proj_unit.sv
// Projection-coefficient engine: streams one Q column and the residual w,
// four lanes per word, and produces u = <Q_j, w> in saturated Q10.13.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   start, q_base  : single-cycle request and Q column word address
//   busy, done     : operation in flight / one-cycle completion pulse
//   rd_en          : read enable for the Q BRAM and the w buffer
//   q_addr, w_addr : word read addresses (registered)
//   vec_q, vec_w   : read data, 1-cycle latency after the address
//   u_out          : signed Q10.13 result, held until the next done
module vec_dot_proj_unit
  import omp_pkg::*;
#(
  parameter int VEC_LEN = 64,
  parameter int QA_W    = 10,
  parameter int WA_W    = 4,
  parameter int ACC_W   = 56
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [QA_W-1:0]          q_base,
  output logic                     busy,
  output logic                     done,
  output logic                     rd_en,
  output logic [QA_W-1:0]          q_addr,
  output logic [WA_W-1:0]          w_addr,
  input  logic [WORD_W-1:0]        vec_q,
  input  logic [WORD_W-1:0]        vec_w,
  output logic signed [DATA_W-1:0] u_out
);

  localparam int NW = VEC_LEN / LANES;

  // Keep Q10.13 when the integer bits above the output field are pure sign;
  // otherwise clamp. Dropping the low FRAC_W bits floors toward -inf.
  function automatic logic signed [DATA_W-1:0] sat_q10_13(input logic signed [ACC_W-1:0] a);
    logic [ACC_W-DATA_W-FRAC_W:0] hi;
    hi = a[ACC_W-1:DATA_W+FRAC_W-1];
    if (&hi || ~|hi) return a[DATA_W+FRAC_W-1:FRAC_W];
    else if (a[ACC_W-1]) return SAT_NEG;
    else return SAT_POS;
  endfunction

  dp_state_t               state, state_nxt;
  logic                    drain_cnt;
  logic                    accept;
  logic                    last_word;
  logic                    vld_p0, vld_p1;
  logic signed [SUM_W-1:0] s_comb, s_p1;
  logic signed [ACC_W-1:0] acc_p2;

  // The done cycle is still busy, so a start there is ignored.
  assign accept    = (state == ST_IDLE) && start && !busy;
  assign last_word = (w_addr == WA_W'(NW - 1));
  assign rd_en     = (state == ST_READ);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept)    state_nxt = ST_READ;
      ST_READ:  if (last_word) state_nxt = ST_DRAIN;
      ST_DRAIN: if (drain_cnt) state_nxt = ST_OUT;
      ST_OUT:                  state_nxt = ST_IDLE;
      default:                 state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      drain_cnt <= 1'b0;
      q_addr    <= '0;
      w_addr    <= '0;
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      acc_p2    <= '0;
      u_out     <= '0;
    end else begin
      state     <= state_nxt;
      done      <= (state == ST_OUT);
      drain_cnt <= (state == ST_DRAIN) ? ~drain_cnt : 1'b0;
      vld_p0    <= rd_en;
      vld_p1    <= vld_p0;

      if (accept)    busy <= 1'b1;
      else if (done) busy <= 1'b0;

      if (accept) begin
        q_addr <= q_base;
        w_addr <= '0;
      end else if (rd_en && !last_word) begin
        q_addr <= q_addr + QA_W'(1);
        w_addr <= w_addr + WA_W'(1);
      end

      if (accept)      acc_p2 <= '0;
      else if (vld_p1) acc_p2 <= acc_p2 + ACC_W'(s_p1);

      if (state == ST_OUT) u_out <= sat_q10_13(acc_p2);
    end
  end

  // p0 -> p1: read data valid, lane products summed and registered
  dot4_lane u_dot4 (
    .vec_a (vec_q),
    .vec_b (vec_w),
    .sum   (s_comb)
  );

  always_ff @(posedge clk) begin
    s_p1 <= s_comb;
  end

endmodule

// File: doc/vec_dot_proj_unit.md
# vec_dot_proj_unit

Sequential projection-coefficient engine for the MGS/OMP datapath. It streams one Q column and the residual buffer w from BRAM, 4 lanes per word, and accumulates the inner product u = ⟨Q_j, w⟩ in Q10.13. The resulting scalar is the `scalar_u` consumed by the downstream subtract-scale stage (w_new = w_old − u·Q_j), so this block is the producer end of that scalar.

## Interface
- `VEC_LEN`, 64: elements per vector; must be a multiple of 4; NW = VEC_LEN/4 words.
- `QA_W`, 10: Q BRAM word-address width.
- `WA_W`, 4: w buffer word-address width; must satisfy 2^WA_W ≥ NW.
- `ACC_W`, 56: accumulator width.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `start`  in  1  single-cycle request; sampled only in IDLE.
- `q_base`  in  QA_W  word address of column j in the Q BRAM; captured on accepted start.
- `busy`  out  1  high from the cycle after start is accepted until the done cycle, inclusive.
- `done`  out  1  one-cycle pulse; `u_out` is valid from this cycle on.
- `rd_en`  out  1  read enable shared by the Q BRAM and the w buffer.
- `q_addr`  out  QA_W  Q read address, q_base + k.
- `w_addr`  out  WA_W  w read address, k.
- `vec_q`  in  96  Q word, lanes {q3,q2,q1,q0}, 24-bit signed Q10.13 each; fixed 1-cycle read latency.
- `vec_w`  in  96  w word, same packing and latency.
- `u_out`  out  24  signed Q10.13 coefficient; holds until the next done.

## Operation
- FSM states: IDLE → READ → DRAIN → OUT → IDLE.
- **IDLE:** on `start`, capture `q_base`, clear k and the accumulator, go to READ.
- **READ:** assert `rd_en`; present k = 0..NW−1, one word per cycle. After k = NW−1, go to DRAIN.
- **DRAIN:** 2 cycles with `rd_en` = 0 to flush the data, lane-sum and accumulate stages.
- **OUT:** register the saturated result into `u_out`, pulse `done`, return to IDLE.
- **Lane math:**
  - p_i = q_i × w_i, signed 24×24 → 48 bits (Q20.26).
  - s = p0+p1+p2+p3, sign-extended to 50 bits, then registered.
  - acc += sign-extended s.
- **Output conversion:**
  - If acc[ACC_W−1:36] is all-equal, u = acc[36:13] (truncation, i.e. floor).
  - Otherwise saturate: 0x7FFFFF if acc is positive, 0x800000 if negative.
- **start while busy:** ignored; no queuing.
- **start in the OUT cycle:** ignored; it is accepted only in IDLE.
- **Reset:** `busy`, `done`, `rd_en` = 0; `q_addr`, `w_addr`, `u_out` = 0; FSM returns to IDLE.
- **Reset mid-operation:** abort immediately; no `done` is issued; the accumulator is cleared.
- **Back-to-back:** a new start is accepted in the cycle after `done`.

## Timing
- Edge E0 samples `start`.
- Address for word k is driven during the cycle after E_k.
- Data for word k is valid after E_{k+1}.
- Lane sum for word k is registered at E_{k+2}.
- Accumulation of word k completes at E_{k+3}.
- `u_out` is registered at E_{NW+3`}; `done` is high for the one cycle after that edge.
- Total latency: NW+3 cycles from the start-sampling edge (19 for VEC_LEN = 64).
- `rd_en` is high for exactly NW consecutive cycles per operation.
- Addresses are registered outputs with no combinational path from `start`.

## Structure
- **Shared package (`omp_pkg`):**
  - DATA_W = 24, FRAC_W = 13, LANES = 4, WORD_W = 96.
  - Q10.13 saturation limits 0x7FFFFF and 0x800000.
  - Lane pack/unpack helpers.
- **Sub-module `dot4_lane`:**
  - Combinational 4-lane multiply and adder tree, 96+96 → 50-bit s.
  - The parent registers its output.
  - Reusable by the subtract-scale stage's verification model.

## Test plan
- VEC_LEN = 16; Q word0 lane0 = 0x002000 (1.0); w word0 lane0 = 0x005000 (2.5); all else 0 → `u_out` = 0x005000; `done` at E0+7.
- VEC_LEN = 16; all Q = 0x002000; all w = 0x001000 (0.5) → `u_out` = 0x010000 (8.0).
- All Q = all w = 0x040000 (32.0), sum 16384 → `u_out` = 0x7FFFFF. Negate w → `u_out` = 0x800000.
- Single lane: q = 0xFFFFFF (−1 LSB), w = 0x001000 (0.5), rest 0 → `u_out` = 0xFFFFFF (floor truncation).
- `start` pulsed again mid-READ → ignored; exactly one `done`; `rd_en` high for exactly NW cycles.
- `rst` asserted at E0+3, `start` reissued with `q_base` = 0x010 → no spurious `done`; first `q_addr` = 0x010; result correct.
